// File: rtl/eq_pkg.sv
// Shared constants for the codec interface: counter geometry, clock tap positions and bit phases.
// Also holds the number of codec settling frames after RSTn rises.
package eq_pkg;
  localparam int              CNT_W          = 11;
  localparam int              MCLK_BIT       = 1;
  localparam int              SCLK_BIT       = 4;
  localparam int              LR_BIT         = 10;
  localparam logic [4:0]      CAP_PHASE      = 5'h0F;
  localparam logic [4:0]      DRV_PHASE      = 5'h1F;
  localparam logic [CNT_W-1:0] CNT_RST       = 11'h400;
  // frames of suppressed valid after the codec leaves reset
  localparam logic [1:0]      STARTUP_FRAMES = 2'd1;
endpackage

// File: rtl/codec_intf.sv
// I2S master for the CS4272: clock generation, SDout deserialization, SDin serialization.
// Received samples and the valid strobe appear one clk after the last right-channel capture.
module codec_intf
  import eq_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] lft_out,
  input  logic signed [SAMPLE_W-1:0] rht_out,
  input  logic                       SDout,
  output logic signed [SAMPLE_W-1:0] lft_in,
  output logic signed [SAMPLE_W-1:0] rht_in,
  output logic                       valid,
  output logic                       MCLK,
  output logic                       SCLK,
  output logic                       LRCLK,
  output logic                       RSTn,
  output logic                       SDin
);

  localparam logic [4:0]       LAST_SLOT = 5'(SAMPLE_W);
  localparam logic [CNT_W-1:0] LAST_CAP  = CNT_W'(1024 + SAMPLE_W * 32 + 15);

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       rstn_q, rstn_d;
  logic [1:0]                 frm_q, frm_d;
  logic                       vld_q, vld_d;
  logic                       sdin_q, sdin_d;
  logic signed [SAMPLE_W-1:0] lsh_q, lsh_d, rsh_q, rsh_d;
  logic signed [SAMPLE_W-1:0] lin_q, lin_d, rin_q, rin_d;
  logic signed [SAMPLE_W-1:0] lsd_q, lsd_d, rsd_q, rsd_d;

  logic [4:0]                 slot;
  logic                       cap;
  logic                       vld_hit;
  logic [5:0]                 nxt_hi;
  logic [4:0]                 nslot;
  logic [SAMPLE_W-1:0]        tx_word;
  logic [SAMPLE_W-1:0]        tx_mask;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    rstn_d  = rstn_q | (cnt_q == '1);
    frm_d   = frm_q;
    if (rstn_q && (cnt_q == '1) && (frm_q != STARTUP_FRAMES)) begin
      frm_d = frm_q + 2'd1;
    end

    slot  = cnt_q[LR_BIT-1:SCLK_BIT+1];
    cap   = (cnt_q[4:0] == CAP_PHASE) && (slot != 5'd0) && (slot <= LAST_SLOT);
    lsh_d = lsh_q;
    rsh_d = rsh_q;
    if (cap) begin
      if (cnt_q[LR_BIT]) rsh_d = SAMPLE_W'({rsh_q, SDout});
      else               lsh_d = SAMPLE_W'({lsh_q, SDout});
    end

    // strobe is registered off the last right capture so both outputs land together
    vld_hit = (cnt_q == LAST_CAP) && (frm_q == STARTUP_FRAMES);
    vld_d   = vld_hit;
    lin_d   = vld_hit ? lsh_d : lin_q;
    rin_d   = vld_hit ? rsh_d : rin_q;

    lsd_d = vld_q ? lft_out : lsd_q;
    rsd_d = vld_q ? rht_out : rsd_q;

    // SDin is loaded so it shows the next slot's bit from the DRV_PHASE cycle onward
    nxt_hi  = cnt_d[LR_BIT:SCLK_BIT+1] + 6'd1;
    nslot   = nxt_hi[4:0];
    tx_word = nxt_hi[5] ? rsd_q : lsd_q;
    tx_mask = SAMPLE_W'(1) << (LAST_SLOT - nslot);
    sdin_d  = sdin_q;
    if (cnt_d[4:0] == DRV_PHASE) begin
      sdin_d = (nslot != 5'd0) && (nslot <= LAST_SLOT) && (|(tx_word & tx_mask));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= CNT_RST;
      rstn_q <= 1'b0;
      frm_q  <= 2'd0;
      vld_q  <= 1'b0;
      sdin_q <= 1'b0;
      lsh_q  <= '0;
      rsh_q  <= '0;
      lin_q  <= '0;
      rin_q  <= '0;
      lsd_q  <= '0;
      rsd_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rstn_q <= rstn_d;
      frm_q  <= frm_d;
      vld_q  <= vld_d;
      sdin_q <= sdin_d;
      lsh_q  <= lsh_d;
      rsh_q  <= rsh_d;
      lin_q  <= lin_d;
      rin_q  <= rin_d;
      lsd_q  <= lsd_d;
      rsd_q  <= rsd_d;
    end
  end

  assign MCLK   = cnt_q[MCLK_BIT];
  assign SCLK   = cnt_q[SCLK_BIT];
  assign LRCLK  = cnt_q[LR_BIT];
  assign RSTn   = rstn_q;
  assign valid  = vld_q;
  assign SDin   = sdin_q;
  assign lft_in = lin_q;
  assign rht_in = rin_q;

endmodule

// File: tb/tb_codec_intf.sv
// Bench for codec_intf: timeline model indexed by clks since reset release, codec/loopback serial source.
module tb_codec_intf;
  localparam int W = 16;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] lft_out, rht_out, lft_in, rht_in;
  logic         SDout, valid, MCLK, SCLK, LRCLK, RSTn, SDin;
  logic         loop, codec_bit;

  assign SDout = loop ? SDin : codec_bit;

  codec_intf #(.SAMPLE_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .lft_out(lft_out), .rht_out(rht_out), .SDout(SDout),
    .lft_in(lft_in), .rht_in(rht_in), .valid(valid), .MCLK(MCLK), .SCLK(SCLK),
    .LRCLK(LRCLK), .RSTn(RSTn), .SDin(SDin)
  );

  int           asserts = 0, fails = 0;
  int           n = 0, pos = 0, f = 0, loop_first = 5;
  logic [W-1:0] samp_l [0:15], samp_r [0:15], obs_l [0:15], obs_r [0:15];
  logic [W-1:0] pres_l, pres_r, exp_l, exp_r, pat;
  logic         sdin_exp, exp_vld;
  int           vld_n [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at n=%0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  // One clk: advance the timeline, drive inputs for this cycle, compare at the falling edge.
  task automatic step();
    int q, s, ch;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      n = 0; exp_l = '0; exp_r = '0; pres_l = '0; pres_r = '0; sdin_exp = 1'b0; loop = 1'b0;
    end else begin
      n++;
    end
    pos = (n + 1024) % 2048;
    f   = (n + 1024) / 2048;
    if (rst_n && pos == 0) begin
      loop      = (f >= loop_first);
      samp_l[f] = (f == 2) ? 16'h8001 : W'($urandom);
      samp_r[f] = (f == 2) ? 16'h7FFE : W'($urandom);
    end
    exp_vld = (n >= 4624) && ((n - 4624) % 2048 == 0);
    if (pos % 32 == 31) begin
      q  = (pos + 1) % 2048;
      s  = (q >> 5) & 31;
      ch = q >> 10;
      sdin_exp = (s >= 1 && s <= W) ? (ch != 0 ? pres_r[W-s] : pres_l[W-s]) : 1'b0;
    end
    lft_out = W'($urandom);
    rht_out = W'($urandom);
    if (exp_vld) begin
      if (loop) begin exp_l = pres_l; exp_r = pres_r; end
      else begin exp_l = samp_l[f]; exp_r = samp_r[f]; end
      if (loop_first == 5 && f == 4) begin lft_out = 16'hA5A5; rht_out = 16'h5A5A; end
      if (loop_first == 5 && f == 5) begin lft_out = 16'h7FFF; rht_out = 16'h8000; end
      pres_l = lft_out;
      pres_r = rht_out;
    end
    s  = (pos >> 5) & 31;
    ch = pos >> 10;
    codec_bit = (s >= 1 && s <= W) ? (ch != 0 ? samp_r[f][W-s] : samp_l[f][W-s]) : 1'($urandom);

    @(negedge clk);
    chk("mclk",   MCLK,   (pos >> 1) & 1);
    chk("sclk",   SCLK,   (pos >> 4) & 1);
    chk("lrclk",  LRCLK,  (pos >> 10) & 1);
    chk("rstn",   RSTn,   (n >= 1024) ? 1 : 0);
    chk("valid",  valid,  exp_vld);
    chk("sdin",   SDin,   sdin_exp);
    chk("lft_in", lft_in, exp_l);
    chk("rht_in", rht_in, exp_r);
    if (valid === 1'b1) begin
      vld_n.push_back(n);
      obs_l[f] = lft_in;
      obs_r[f] = rht_in;
    end
    s = (pos >> 5) & 31;
    if (loop_first == 5 && f == 5 && pos < 1024 && pos % 32 == 15 && s >= 1 && s <= W)
      pat = {pat[W-2:0], SDin};
  endtask

  initial begin
    rst_n = 1'b0; loop = 1'b0; codec_bit = 1'b0; lft_out = '0; rht_out = '0;
    pres_l = '0; pres_r = '0; exp_l = '0; exp_r = '0; sdin_exp = 1'b0; exp_vld = 1'b0; pat = '0;
    for (int i = 0; i < 16; i++) begin
      samp_l[i] = '0; samp_r[i] = '0; obs_l[i] = '0; obs_r[i] = '0;
    end

    repeat (4) step();
    rst_n = 1'b1;
    for (int k = 0; k < 30000 && !(f == 9 && pos == 'h300); k++) begin
      step();
      if (n == 1023) chk("rstn_before_wrap", RSTn, 0);
      if (n == 1024) chk("rstn_at_wrap", RSTn, 1);
    end

    chk("valid_count", vld_n.size(), 7);
    chk("valid_first", (vld_n.size() > 0) ? vld_n[0] : -1, 4624);
    chk("valid_second", (vld_n.size() > 1) ? vld_n[1] : -1, 6672);
    chk("valid_third", (vld_n.size() > 2) ? vld_n[2] : -1, 8720);
    chk("rx_codec_left", obs_l[2], 16'h8001);
    chk("rx_codec_right", obs_r[2], 16'h7FFE);
    chk("tx_pattern_left", pat, 16'hA5A5);
    chk("loop_left", obs_l[5], 16'hA5A5);
    chk("loop_right", obs_r[5], 16'h5A5A);
    chk("loop_max_pos", obs_l[6], 16'h7FFF);
    chk("loop_min_neg", obs_r[6], 16'h8000);

    // reset in the middle of a frame, then restart the start-up sequence
    rst_n = 1'b0;
    step();
    chk("midreset_rstn", RSTn, 0);
    chk("midreset_lrclk", LRCLK, 1);
    chk("midreset_lft_in", lft_in, 0);
    step();
    step();
    rst_n = 1'b1;
    loop_first = 99;
    vld_n.delete();
    for (int i = 0; i < 16; i++) begin obs_l[i] = '0; obs_r[i] = '0; end
    repeat (4700) step();
    chk("rerelease_valid_first", (vld_n.size() > 0) ? vld_n[0] : -1, 4624);
    chk("rerelease_valid_count", vld_n.size(), 1);
    chk("rerelease_rx_left", obs_l[2], 16'h8001);
    chk("rerelease_rx_right", obs_r[2], 16'h7FFE);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
